// File: rtl/mmss_countdown_timer_if.sv
// -----------------------------------------------------------------------------
// mmss_countdown_timer_if
//
// Purpose:
//   Bundles the keypad/control strobes and the display/status outputs of the
//   MM:SS countdown timer so the controller and the timer can be connected
//   with a single port.
//
// Parameters:
//   MIN_DIGITS  number of BCD minute digits (1..4); total digits ND = MIN_DIGITS+2
//
// Signals (direction as seen from the timer, i.e. the slave modport):
//   tick       in   1       one-cycle pulse per second
//   key_valid  in   1       one-cycle strobe, key_digit valid
//   key_digit  in   4       entered digit, legal 0..9
//   start      in   1       one-cycle strobe, start/resume
//   stop       in   1       one-cycle strobe, pause/cancel
//   clear      in   1       one-cycle strobe, cancel and zero
//   digits     out  4*ND    BCD value, [3:0] sec ones, [7:4] sec tens, minutes upward
//   state      out  2       0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
//   running    out  1       state == RUN
//   zero       out  1       all digits zero
//   done       out  1       one-cycle pulse on entry to DONE
//
// Strobe semantics: every input strobe is a single-cycle pulse sampled on the
// rising clk edge; there is no back-pressure, so a strobe is either acted on
// in the cycle it is high or deliberately ignored according to the current
// state and the strobe priority clear > stop > start > key_valid/tick.
// -----------------------------------------------------------------------------
interface mmss_countdown_timer_if #(
    parameter int MIN_DIGITS = 2
);
    localparam int ND = MIN_DIGITS + 2;

    logic              tick;
    logic              key_valid;
    logic [3:0]        key_digit;
    logic              start;
    logic              stop;
    logic              clear;
    logic [4*ND-1:0]   digits;
    logic [1:0]        state;
    logic              running;
    logic              zero;
    logic              done;

    // Keypad decoder / controller side.
    modport master (
        output tick,
        output key_valid,
        output key_digit,
        output start,
        output stop,
        output clear,
        input  digits,
        input  state,
        input  running,
        input  zero,
        input  done
    );

    // Timer side.
    modport slave (
        input  tick,
        input  key_valid,
        input  key_digit,
        input  start,
        input  stop,
        input  clear,
        output digits,
        output state,
        output running,
        output zero,
        output done
    );
endinterface

// File: rtl/mmss_countdown_timer.sv
// -----------------------------------------------------------------------------
// mmss_countdown_timer
//
// Purpose:
//   Multi-digit MM:SS countdown timer for the microwave controller. Digits are
//   entered by shifting keypad digits in from the right, the value counts down
//   on an external 1 Hz tick through a BCD borrow chain (seconds ones mod 10,
//   seconds tens mod 6, minute digits mod 10), and a run/pause/done state
//   machine sequences the whole thing.
//
// Parameters:
//   MIN_DIGITS  number of BCD minute digits (1..4); total digits ND = MIN_DIGITS+2
//
// Ports:
//   clk   in   system clock, rising edge
//   clrn  in   asynchronous active-low reset
//   bus   slave modport of mmss_countdown_timer_if (strobes in, digits/status out)
//
// Build option:
//   TIMER_ADD30_EN  when defined, start on a zero value in IDLE loads 00:30 and
//                   runs, and start while running adds 30 seconds (saturating
//                   at all-9 minutes, 59 seconds). When undefined, both of
//                   those starts are ignored.
//
// Outputs digits, state and done are registered; running and zero are decoded
// combinationally from the registered state and digits.
// -----------------------------------------------------------------------------
module mmss_countdown_timer #(
    parameter int MIN_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    clrn,
    mmss_countdown_timer_if.slave   bus
);
    localparam int ND = MIN_DIGITS + 2;
    localparam int W  = 4 * ND;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    digits_q, digits_d;
    logic            done_q, done_d;
    logic            zero_w;

    // -------------------------------------------------------------------------
    // One-second decrement through the BCD borrow chain. The borrow starts at
    // the seconds-ones digit and ripples upward only while digits are zero.
    // The seconds-tens digit wraps to 5; a keyed-in tens value above 5 simply
    // decrements, so 0:99 counts 0:98, 0:97, ... rather than being corrected.
    // -------------------------------------------------------------------------
    function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        logic [3:0]   d;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < ND; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    r[4*i +: 4] = d - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

`ifdef TIMER_ADD30_EN
    // -------------------------------------------------------------------------
    // Add 30 seconds. Seconds are handled as a binary value s = tens*10+ones
    // so that keyed-in values like 0:99 still add correctly; a result of 60
    // or more gives back 60 and carries one into the BCD minute digits. A
    // carry out of the top minute digit saturates the display at 9..9:59.
    // -------------------------------------------------------------------------
    function automatic logic [W-1:0] add30(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [7:0]   s;
        logic         carry;
        logic [3:0]   d;
        r     = v;
        s     = 8'(v[7:4]) * 8'd10 + 8'(v[3:0]) + 8'd30;
        carry = 1'b0;
        if (s >= 8'd60) begin
            s     = s - 8'd60;
            carry = 1'b1;
        end
        r[7:4] = 4'(s / 8'd10);
        r[3:0] = 4'(s % 8'd10);
        for (int i = 2; i < ND; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
                if (d >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        if (carry) begin
            for (int i = 2; i < ND; i++) begin
                r[4*i +: 4] = 4'd9;
            end
            r[7:0] = 8'h59;
        end
        return r;
    endfunction
`endif

    assign zero_w = (digits_q == '0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= ST_IDLE;
            digits_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            done_q   <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-digits logic. Each state resolves its strobes in
    // priority order clear > stop > start > key_valid/tick, so at most one
    // action is taken per cycle and a tick that arrives with a higher-priority
    // strobe is dropped.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.clear) begin
                    digits_d = '0;
                end else if (bus.stop) begin
                    // stop has nothing to cancel here, but still masks a key
                end else if (bus.start) begin
                    if (!zero_w) begin
                        state_d = ST_RUN;
                    end
`ifdef TIMER_ADD30_EN
                    else begin
                        digits_d = W'(8'h30);
                        state_d  = ST_RUN;
                    end
`endif
                end else if (bus.key_valid && (bus.key_digit <= 4'd9)) begin
                    // Shift left one digit; the most significant digit falls off.
                    digits_d = {digits_q[W-5:0], bus.key_digit};
                end
            end

            ST_RUN: begin
                if (bus.clear) begin
                    state_d  = ST_IDLE;
                    digits_d = '0;
                end else if (bus.stop) begin
                    state_d = ST_PAUSE;
                end
`ifdef TIMER_ADD30_EN
                else if (bus.start) begin
                    digits_d = add30(digits_q);
                end
`endif
                else if (bus.tick) begin
                    // The last second lands on zero and finishes; a zero value
                    // in RUN is treated the same way rather than wrapping.
                    if ((digits_q == W'(1)) || zero_w) begin
                        digits_d = '0;
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                    end else begin
                        digits_d = dec_bcd(digits_q);
                    end
                end
            end

            ST_PAUSE: begin
                if (bus.clear || bus.stop) begin
                    state_d  = ST_IDLE;
                    digits_d = '0;
                end else if (bus.start) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                digits_d = '0;
                // Any user action acknowledges completion; a key press here
                // only leaves DONE and is not entered as a digit.
                if (bus.start || bus.stop || bus.clear || bus.key_valid) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                digits_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.digits  = digits_q;
    assign bus.state   = state_q;
    assign bus.running = (state_q == ST_RUN);
    assign bus.zero    = zero_w;
    assign bus.done    = done_q;

endmodule
